// File: rtl/fft_uart_scheduler_pkg.sv
// Shared constants for the FFT-to-UART frame scheduler: sync bytes, FSM encodings, helpers.
package fft_uart_scheduler_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 24;

    localparam logic [BYTE_W-1:0] SYNC0_DEF = 8'hA5;
    localparam logic [BYTE_W-1:0] SYNC1_DEF = 8'h5A;

    localparam logic [0:0] C_WAIT_SYNC = 1'b0;
    localparam logic [0:0] C_FILL      = 1'b1;

    localparam logic [2:0] T_IDLE = 3'd0;
    localparam logic [2:0] T_HDR0 = 3'd1;
    localparam logic [2:0] T_HDR1 = 3'd2;
    localparam logic [2:0] T_SEQ  = 3'd3;
    localparam logic [2:0] T_DATA = 3'd4;
    localparam logic [2:0] T_CSUM = 3'd5;

    // Saturating 8-bit increment for the event counters.
    function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fft_uart_scheduler_buffer.sv
// Ping-pong frame store: simple dual-port RAM with a registered (1-cycle) read port.
module fft_frame_buffer #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 22
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_uart_scheduler.sv
// Captures FFT frames into a ping-pong buffer and streams each one to a UART as
// A5 5A seq data... csum, overlapping capture of the next frame with transmission.
module fft_uart_scheduler
    import fft_uart_scheduler_pkg::*;
#(
    parameter int unsigned FFT_LEN = 64,
    parameter int unsigned DATA_W  = 22,
    parameter logic [7:0]  SYNC0   = SYNC0_DEF,
    parameter logic [7:0]  SYNC1   = SYNC1_DEF
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              i_enable,
    input  logic              i_fft_ce,
    input  logic              i_fft_sync,
    input  logic [DATA_W-1:0] i_fft_data,
    output logic              o_tx_wr,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy,
    output logic              o_frame_sent,
    output logic [7:0]        o_drop_count,
    output logic [7:0]        o_resync_count,
    output logic              o_busy
);

    localparam int unsigned IDX_W = $clog2(FFT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

    logic [0:0]        c_state, c_next;
    logic [IDX_W-1:0]  idx, idx_d, widx;
    logic              wr_sel, wr_sel_d, we, drop_inc, resync_inc;
    logic [1:0]        full, full_d, set_full, clr_full;

    logic [2:0]        t_state, t_next;
    logic              tx_wr_d, sent_d, busy_d, load_word, accept;
    logic [7:0]        tx_data_d, csum, csum_d, seq, seq_d;
    logic [15:0]       word_q, word_d;
    logic [IDX_W-1:0]  w, w_d;
    logic [1:0]        b, b_d;
    logic              last, last_d, rd_sel, rd_sel_d;
    logic [DATA_W-1:0] rd_data;
    logic [WORD_W-1:0] rd_word;

    fft_frame_buffer #(
        .ADDR_W(IDX_W + 1),
        .DATA_W(DATA_W)
    ) u_buf (
        .clk  (sys_clock),
        .we   (we),
        .waddr({wr_sel, widx}),
        .wdata(i_fft_data),
        .raddr({rd_sel, w}),
        .rdata(rd_data)
    );

    assign rd_word = WORD_W'(rd_data);
    assign accept  = o_tx_wr & ~i_tx_busy;

    // Capture: fill buffer wr_sel starting at a sync word; restart on an early sync.
    always_comb begin
        c_next     = c_state;
        idx_d      = idx;
        widx       = idx;
        wr_sel_d   = wr_sel;
        we         = 1'b0;
        set_full   = 2'b00;
        drop_inc   = 1'b0;
        resync_inc = 1'b0;
        case (c_state)
            C_WAIT_SYNC: begin
                if (i_fft_ce && i_fft_sync && i_enable) begin
                    if (!full[wr_sel]) begin
                        we     = 1'b1;
                        widx   = '0;
                        idx_d  = IDX_W'(1);
                        c_next = C_FILL;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            C_FILL: begin
                if (i_fft_ce) begin
                    we = 1'b1;
                    if (i_fft_sync) begin
                        widx       = '0;
                        idx_d      = IDX_W'(1);
                        resync_inc = 1'b1;
                    end else if (idx == LAST_IDX) begin
                        set_full[wr_sel] = 1'b1;
                        wr_sel_d         = ~wr_sel;
                        idx_d            = '0;
                        c_next           = C_WAIT_SYNC;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            default: c_next = C_WAIT_SYNC;
        endcase
    end

    // Transmit: word_q holds bytes 1-2 so the next word's read overlaps them.
    always_comb begin
        t_next    = t_state;
        tx_wr_d   = o_tx_wr;
        tx_data_d = o_tx_data;
        csum_d    = csum;
        word_d    = word_q;
        w_d       = w;
        b_d       = b;
        last_d    = last;
        seq_d     = seq;
        rd_sel_d  = rd_sel;
        clr_full  = 2'b00;
        sent_d    = 1'b0;
        load_word = 1'b0;
        case (t_state)
            T_IDLE: begin
                if (full[rd_sel]) begin
                    t_next    = T_HDR0;
                    tx_wr_d   = 1'b1;
                    tx_data_d = SYNC0;
                    csum_d    = '0;
                end
            end
            T_HDR0: if (accept) begin
                t_next    = T_HDR1;
                tx_data_d = SYNC1;
            end
            T_HDR1: if (accept) begin
                t_next    = T_SEQ;
                tx_data_d = seq;
            end
            T_SEQ: if (accept) begin
                t_next    = T_DATA;
                csum_d    = csum + o_tx_data;
                load_word = 1'b1;
            end
            T_DATA: if (accept) begin
                csum_d = csum + o_tx_data;
                case (b)
                    2'd0: begin
                        tx_data_d = word_q[15:8];
                        b_d       = 2'd1;
                    end
                    2'd1: begin
                        tx_data_d = word_q[7:0];
                        b_d       = 2'd2;
                    end
                    default: begin
                        if (last) begin
                            t_next    = T_CSUM;
                            tx_data_d = csum + o_tx_data;
                        end else begin
                            load_word = 1'b1;
                        end
                    end
                endcase
            end
            T_CSUM: if (accept) begin
                t_next           = T_IDLE;
                tx_wr_d          = 1'b0;
                sent_d           = 1'b1;
                clr_full[rd_sel] = 1'b1;
                rd_sel_d         = ~rd_sel;
                seq_d            = seq + 8'd1;
            end
            default: begin
                t_next  = T_IDLE;
                tx_wr_d = 1'b0;
            end
        endcase
        if (load_word) begin
            tx_data_d = rd_word[23:16];
            word_d    = rd_word[15:0];
            w_d       = w + IDX_W'(1);
            last_d    = (w == LAST_IDX);
            b_d       = 2'd0;
        end
        busy_d = (t_next != T_IDLE);
        full_d = (full & ~clr_full) | set_full;
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            c_state        <= C_WAIT_SYNC;
            idx            <= '0;
            wr_sel         <= 1'b0;
            full           <= 2'b00;
            t_state        <= T_IDLE;
            o_tx_wr        <= 1'b0;
            o_tx_data      <= '0;
            csum           <= '0;
            word_q         <= '0;
            w              <= '0;
            b              <= '0;
            last           <= 1'b0;
            seq            <= '0;
            rd_sel         <= 1'b0;
            o_frame_sent   <= 1'b0;
            o_busy         <= 1'b0;
            o_drop_count   <= '0;
            o_resync_count <= '0;
        end else begin
            c_state      <= c_next;
            idx          <= idx_d;
            wr_sel       <= wr_sel_d;
            full         <= full_d;
            t_state      <= t_next;
            o_tx_wr      <= tx_wr_d;
            o_tx_data    <= tx_data_d;
            csum         <= csum_d;
            word_q       <= word_d;
            w            <= w_d;
            b            <= b_d;
            last         <= last_d;
            seq          <= seq_d;
            rd_sel       <= rd_sel_d;
            o_frame_sent <= sent_d;
            o_busy       <= busy_d;
            if (drop_inc) begin
                o_drop_count <= sat_inc(o_drop_count);
            end
            if (resync_inc) begin
                o_resync_count <= sat_inc(o_resync_count);
            end
        end
    end

endmodule
